// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, recovered byte plus status strobes out.
// slave = the receiver itself, master = whatever drives the line and consumes bytes.
interface uart_rx_if;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   modport slave  (input  rx, output data_out, data_valid, frame_err, busy);
   modport master (output rx, input  data_out, data_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-FF input synchroniser and internal mid-bit sampling.
// Emits a one-cycle data_valid for a good stop bit, or a one-cycle frame_err for a low one.
module uart_rx #(
   parameter int unsigned CLOCK_FREQ = 50000000,
   parameter int unsigned BAUD_RATE  = 921600
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);
   localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_e;

   state_e           state_q;
   logic [1:0]       sync_q;
   logic [CNT_W-1:0] clk_cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic [7:0]       data_out_q;
   logic             data_valid_q;
   logic             frame_err_q;
   logic             busy_q;
   logic             rx_s;

   assign rx_s = sync_q[1];

   // Single-process FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sync_q       <= 2'b11;
         clk_cnt_q    <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         sync_q       <= {sync_q[0], bus.rx};
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_q   <= START;
                  clk_cnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            START: begin
               if (clk_cnt_q == HALF_LAST) begin
                  clk_cnt_q <= '0;
                  bit_idx_q <= '0;
                  // A line that has gone high again by mid-start is a glitch, not a frame.
                  if (!rx_s) begin
                     state_q <= DATA;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
            DATA: begin
               if (clk_cnt_q == BIT_LAST) begin
                  clk_cnt_q <= '0;
                  shift_q   <= {rx_s, shift_q[7:1]};
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
            STOP: begin
               if (clk_cnt_q == BIT_LAST) begin
                  clk_cnt_q <= '0;
                  if (rx_s) begin
                     data_out_q   <= shift_q;
                     data_valid_q <= 1'b1;
                     state_q      <= IDLE;
                     busy_q       <= 1'b0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= BREAK_WAIT;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_W'(1);
               end
            end
            BREAK_WAIT: begin
               // Hold off until the line recovers so a break cannot look like a new start.
               if (rx_s) begin
                  state_q   <= IDLE;
                  clk_cnt_q <= '0;
                  busy_q    <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               clk_cnt_q <= '0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames on rx, scoreboards received bytes,
// and checks strobes, busy, latency, reset and baud tolerance.
module tb_uart_rx;
   localparam int CPB = 54;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_rx_if bus();

   uart_rx #(.CLOCK_FREQ(50000000), .BAUD_RATE(921600)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned cyc = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  obs_q[$];
   int unsigned obs_cyc[$];
   int          rd_idx = 0;
   int          dv_cnt = 0;
   int          fe_cnt = 0;
   int          overlap_cnt = 0;
   int          wide_cnt = 0;
   logic        dv_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: record every received byte and its cycle; track strobe anomalies.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.data_valid) begin
            obs_q.push_back(bus.data_out);
            obs_cyc.push_back(cyc);
            dv_cnt++;
         end
         if (bus.frame_err) fe_cnt++;
         if (bus.data_valid && bus.frame_err) overlap_cnt++;
         if (bus.data_valid && dv_prev) wide_cnt++;
      end
      dv_prev = bus.data_valid;
   end

   // Drive one frame starting now (call just after a posedge); push expected byte if pushed.
   task automatic send_frame(input logic [7:0] b, input int cpb, input bit stop, input bit push,
                             output bit busy_ok, output int unsigned edge_cyc);
      busy_ok  = 1'b1;
      edge_cyc = cyc + 1;
      if (push) exp_q.push_back(b);
      bus.rx = 1'b0;
      repeat (cpb) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         repeat (cpb / 2) @(posedge clk);
         @(negedge clk);
         if (!bus.busy) busy_ok = 1'b0;
         repeat (cpb - cpb / 2) @(posedge clk);
      end
      bus.rx = stop;
      repeat (cpb) @(posedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.rx = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL reset_data_out got=%h exp=00", bus.data_out); end
      n_cmp++; if (bus.data_valid !== 1'b0) begin n_err++; $display("FAIL reset_data_valid got=%b exp=0", bus.data_valid); end
      n_cmp++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      @(posedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
   endtask

   task automatic test_basic;
      int dv0, fe0, lat;
      bit bok;
      int unsigned ec;
      logic [7:0] e;
      dv0 = dv_cnt; fe0 = fe_cnt;
      send_frame(8'hA5, CPB, 1'b1, 1'b1, bok, ec);
      @(negedge clk);
      lat = (obs_cyc.size() > rd_idx) ? int'(obs_cyc[rd_idx] - ec) : 0;
      n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%b exp=1", bok); end
      n_cmp++; if (dv_cnt - dv0 !== 1) begin n_err++; $display("FAIL basic_dv_count got=%0d exp=1", dv_cnt - dv0); end
      n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL basic_fe_count got=%0d exp=0", fe_cnt - fe0); end
      n_cmp++; if (bus.data_out !== 8'hA5) begin n_err++; $display("FAIL basic_data_out got=%h exp=a5", bus.data_out); end
      n_cmp++; if (lat < 513 || lat > 517) begin n_err++; $display("FAIL basic_latency got=%0d exp=515+-2", lat); end
      while (rd_idx < obs_q.size()) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_unexpected got=%h exp=none", obs_q[rd_idx]); end
         else begin e = exp_q.pop_front(); if (obs_q[rd_idx] !== e) begin n_err++; $display("FAIL sb_basic got=%h exp=%h", obs_q[rd_idx], e); end end
         rd_idx++;
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_basic_missing got=%0d pending exp=0", exp_q.size()); exp_q.delete(); end
      @(posedge clk);
   endtask

   task automatic test_glitch;
      int dv0, fe0;
      bit bok;
      int unsigned ec;
      logic [7:0] e;
      dv0 = dv_cnt; fe0 = fe_cnt;
      bus.rx = 1'b0;
      repeat (10) @(posedge clk);
      bus.rx = 1'b1;
      repeat (60) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy got=%b exp=0", bus.busy); end
      n_cmp++; if (dv_cnt - dv0 !== 0) begin n_err++; $display("FAIL glitch_dv_count got=%0d exp=0", dv_cnt - dv0); end
      n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL glitch_fe_count got=%0d exp=0", fe_cnt - fe0); end
      @(posedge clk);
      send_frame(8'h3C, CPB, 1'b1, 1'b1, bok, ec);
      @(negedge clk);
      n_cmp++; if (bus.data_out !== 8'h3C) begin n_err++; $display("FAIL glitch_next_data got=%h exp=3c", bus.data_out); end
      while (rd_idx < obs_q.size()) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_unexpected got=%h exp=none", obs_q[rd_idx]); end
         else begin e = exp_q.pop_front(); if (obs_q[rd_idx] !== e) begin n_err++; $display("FAIL sb_glitch got=%h exp=%h", obs_q[rd_idx], e); end end
         rd_idx++;
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_glitch_missing got=%0d pending exp=0", exp_q.size()); exp_q.delete(); end
      @(posedge clk);
   endtask

   task automatic test_frame_err;
      int dv0, fe0;
      bit bok;
      int unsigned ec;
      logic [7:0] e;
      dv0 = dv_cnt; fe0 = fe_cnt;
      send_frame(8'h81, CPB, 1'b0, 1'b0, bok, ec);
      repeat (200) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ferr_busy_break got=%b exp=1", bus.busy); end
      n_cmp++; if (fe_cnt - fe0 !== 1) begin n_err++; $display("FAIL ferr_fe_count got=%0d exp=1", fe_cnt - fe0); end
      n_cmp++; if (dv_cnt - dv0 !== 0) begin n_err++; $display("FAIL ferr_dv_count got=%0d exp=0", dv_cnt - dv0); end
      n_cmp++; if (bus.data_out !== 8'h3C) begin n_err++; $display("FAIL ferr_data_hold got=%h exp=3c", bus.data_out); end
      @(posedge clk);
      bus.rx = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy_release got=%b exp=0", bus.busy); end
      @(posedge clk);
      send_frame(8'h3C, CPB, 1'b1, 1'b1, bok, ec);
      @(negedge clk);
      n_cmp++; if (dv_cnt - dv0 !== 1) begin n_err++; $display("FAIL ferr_next_dv got=%0d exp=1", dv_cnt - dv0); end
      while (rd_idx < obs_q.size()) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_unexpected got=%h exp=none", obs_q[rd_idx]); end
         else begin e = exp_q.pop_front(); if (obs_q[rd_idx] !== e) begin n_err++; $display("FAIL sb_ferr got=%h exp=%h", obs_q[rd_idx], e); end end
         rd_idx++;
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_ferr_missing got=%0d pending exp=0", exp_q.size()); exp_q.delete(); end
      @(posedge clk);
   endtask

   task automatic test_back_to_back;
      int dv0, fe0, base, gap;
      bit bok;
      int unsigned ec;
      logic [7:0] e;
      dv0 = dv_cnt; fe0 = fe_cnt; base = rd_idx;
      send_frame(8'h00, CPB, 1'b1, 1'b1, bok, ec);
      send_frame(8'hFF, CPB, 1'b1, 1'b1, bok, ec);
      send_frame(8'h55, CPB, 1'b1, 1'b1, bok, ec);
      @(negedge clk);
      n_cmp++; if (dv_cnt - dv0 !== 3) begin n_err++; $display("FAIL b2b_dv_count got=%0d exp=3", dv_cnt - dv0); end
      n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL b2b_fe_count got=%0d exp=0", fe_cnt - fe0); end
      for (int i = 1; i < 3; i++) begin
         if (obs_cyc.size() > base + i) begin
            gap = int'(obs_cyc[base + i] - obs_cyc[base + i - 1]);
            n_cmp++; if (gap < 535 || gap > 545) begin n_err++; $display("FAIL b2b_gap%0d got=%0d exp=540", i, gap); end
         end
      end
      while (rd_idx < obs_q.size()) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_unexpected got=%h exp=none", obs_q[rd_idx]); end
         else begin e = exp_q.pop_front(); if (obs_q[rd_idx] !== e) begin n_err++; $display("FAIL sb_b2b got=%h exp=%h", obs_q[rd_idx], e); end end
         rd_idx++;
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_b2b_missing got=%0d pending exp=0", exp_q.size()); exp_q.delete(); end
      repeat (20) @(posedge clk);
   endtask

   task automatic test_reset_mid;
      int dv0;
      bit bok;
      int unsigned ec;
      logic [7:0] e;
      dv0 = dv_cnt;
      // 0xF0: bits 4..7 are 1, so the rest of the aborted frame keeps the line high.
      fork
         send_frame(8'hF0, CPB, 1'b1, 1'b0, bok, ec);
         begin
            repeat (5 * CPB + CPB / 2) @(posedge clk);
            rst = 1'b1;
            @(posedge clk);
            rst = 1'b0;
            @(negedge clk);
            n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
            n_cmp++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL rstmid_data_out got=%h exp=00", bus.data_out); end
         end
      join
      repeat (20) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (dv_cnt - dv0 !== 0) begin n_err++; $display("FAIL rstmid_no_dv got=%0d exp=0", dv_cnt - dv0); end
      @(posedge clk);
      send_frame(8'h5A, CPB, 1'b1, 1'b1, bok, ec);
      @(negedge clk);
      n_cmp++; if (bus.data_out !== 8'h5A) begin n_err++; $display("FAIL rstmid_next_data got=%h exp=5a", bus.data_out); end
      while (rd_idx < obs_q.size()) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_unexpected got=%h exp=none", obs_q[rd_idx]); end
         else begin e = exp_q.pop_front(); if (obs_q[rd_idx] !== e) begin n_err++; $display("FAIL sb_rstmid got=%h exp=%h", obs_q[rd_idx], e); end end
         rd_idx++;
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_rstmid_missing got=%0d pending exp=0", exp_q.size()); exp_q.delete(); end
      @(posedge clk);
   endtask

   task automatic test_baud_err;
      int fe0;
      bit bok;
      int unsigned ec;
      logic [7:0] e;
      int rates[2] = '{53, 55};
      fe0 = fe_cnt;
      foreach (rates[r]) begin
         send_frame(8'hC3, rates[r], 1'b1, 1'b1, bok, ec);
         @(negedge clk);
         n_cmp++; if (bus.data_out !== 8'hC3) begin n_err++; $display("FAIL baud%0d_data got=%h exp=c3", rates[r], bus.data_out); end
         n_cmp++; if (fe_cnt - fe0 !== 0) begin n_err++; $display("FAIL baud%0d_fe got=%0d exp=0", rates[r], fe_cnt - fe0); end
         repeat (20) @(posedge clk);
      end
      while (rd_idx < obs_q.size()) begin
         n_cmp++;
         if (exp_q.size() == 0) begin n_err++; $display("FAIL sb_unexpected got=%h exp=none", obs_q[rd_idx]); end
         else begin e = exp_q.pop_front(); if (obs_q[rd_idx] !== e) begin n_err++; $display("FAIL sb_baud got=%h exp=%h", obs_q[rd_idx], e); end end
         rd_idx++;
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_baud_missing got=%0d pending exp=0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_pulses;
      n_cmp++; if (overlap_cnt !== 0) begin n_err++; $display("FAIL pulse_overlap got=%0d exp=0", overlap_cnt); end
      n_cmp++; if (wide_cnt !== 0) begin n_err++; $display("FAIL pulse_width got=%0d exp=0", wide_cnt); end
   endtask

   initial begin
      bus.rx = 1'b1;
      test_reset;
      test_basic;
      test_glitch;
      test_frame_err;
      test_back_to_back;
      test_reset_mid;
      test_baud_err;
      test_pulses;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Recovers bytes from the asynchronous serial input `rx` and presents each one as a single-cycle valid strobe to downstream logic.
- Pairs with the existing clock-enable baud generator and the transmit path in the same clock domain. Uses identical CLOCK_FREQ/BAUD_RATE parameterisation, so both ends agree on the bit period.
- Derives its own mid-bit sampling internally. No external tick input.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 921600, serial bit rate in bits/s.
- CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (integer divide, 54 at defaults), clocks per bit period.
- HALF_BIT, CLKS_PER_BIT/2 (27 at defaults), clocks from start-edge detection to the start-bit mid-sample.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- data_out  output  8  last correctly received byte; holds until the next good byte.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - Applies on any clk edge with rst=1, in any state, including mid-frame.
  - data_out=0x00, data_valid=0, frame_err=0, busy=0.
  - State=IDLE; bit counter and bit index cleared.
  - Both synchronizer stages set to 1, so a reset never produces a false start.
- Input synchroniser:
  - rx passes through a 2-FF synchroniser; rx_s is the output.
  - All decisions use rx_s only. Adds 2 clocks of latency.
- Counters:
  - clk_cnt is wide enough for CLKS_PER_BIT-1 and wraps to 0 on every state transition.
  - bit_idx is 3 bits.
- State IDLE:
  - busy=0.
  - rx_s==0 -> START, clk_cnt=0.
- State START:
  - clk_cnt increments each clock.
  - At clk_cnt==HALF_BIT-1: rx_s==0 -> DATA, clk_cnt=0, bit_idx=0; otherwise treat as a glitch -> IDLE with no output pulse.
- State DATA:
  - At clk_cnt==CLKS_PER_BIT-1: shift rx_s into the MSB of the shift register (LSB-first line order) and clear clk_cnt.
  - bit_idx==7 -> STOP; otherwise bit_idx+1.
- State STOP:
  - At clk_cnt==CLKS_PER_BIT-1:
    - rx_s==1: data_out<=shift register, data_valid=1 for exactly one clock, -> IDLE.
    - rx_s==0: frame_err=1 for exactly one clock, data_out unchanged, -> BREAK_WAIT.
- State BREAK_WAIT:
  - Stays until rx_s==1, then -> IDLE.
  - Prevents a held-low or break line from re-triggering START.
- Timing properties:
  - Sampling lands at mid-bit (±1 clock).
  - Stop bit is sampled at its midpoint, so the receiver returns to IDLE half a bit early. Back-to-back frames with zero idle bits must be received.
  - data_valid and frame_err are never high in the same cycle.
  - Each received frame produces exactly one of the two pulses, or neither for a rejected glitch.
- Latency: data_valid rises 27+9*54=513 clocks after rx_s first reads 0, i.e. 515–516 clocks after the raw rx falling edge at defaults.

Test Plan:
- Reset then frame 0xA5 (LSB first, 54 clk/bit, stop=1) -> single data_valid pulse 515±2 clocks after the start edge; data_out=0xA5; busy high for the whole frame; frame_err stays 0.
- rx low for 10 clocks then high -> returns to IDLE after the start mid-check; no data_valid, no frame_err; a following 0x3C frame is received as 0x3C.
- Frame 0x81 with stop bit 0, rx held low 200 clocks, then frame 0x3C -> one frame_err pulse; data_out stays at its prior value; busy held through BREAK_WAIT; then data_valid with data_out=0x3C.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle between stop and next start -> three data_valid pulses about 540 clocks apart, values in order, no frame_err.
- rst pulsed 1 cycle during data bit 4 of a frame -> next clock: busy=0 and data_out=0x00; remainder of the aborted frame must not produce data_valid; following frame 0x5A is received correctly.
- ±2% baud error on the stimulus (53 and 55 clk/bit) with frame 0xC3 -> data_out=0xC3, no frame_err.
